gray_counter_n: RTL and testbench
=================================

Name: gray_counter_n

Overview:
- Parametrised Gray-code counter, successor to the fixed 3-bit Gray counter.
- Features: configurable width, up/down count, parallel load, wrap or saturate at the ends, sticky overflow/underflow flags with explicit clear.
- Drives multi-bit pointers that cross clock domains (FIFO pointers) and test-pattern generators in the P-series datapath.

Parameters:
- WIDTH, 3, counter width in bits, ≥2.
- WRAP, 1, 1 = wrap at the ends; 0 = saturate at the ends.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- En  in  1  count enable.
- Dir  in  1  1 = count up, 0 = count down.
- Load  in  1  synchronous parallel load.
- LoadVal  in  WIDTH  binary value to load.
- ClrFlags  in  1  synchronous clear of the sticky flags.
- Output  out  WIDTH  Gray code of the current count (registered).
- BinOut  out  WIDTH  binary form of the current count (registered).
- Overflow  out  1  sticky; set on an up step from the maximum count.
- Underflow  out  1  sticky; set on a down step from 0.

Behaviour:
- Reset low (async): BinOut=0, Output=0, Overflow=0, Underflow=0. State holds at these values while Reset stays low. After release, the first rising edge applies normal rules.
- Internal state is the binary count B. Output always equals B ^ (B>>1), registered on the same edge as B. No lag between BinOut and Output.
- Priority per edge: Load > En. ClrFlags is evaluated independently of Load/En.
- Load=1: B <= LoadVal. Output <= LoadVal ^ (LoadVal>>1) on the same edge. Flags are not set by a load.
- En=1, Load=0, Dir=1:
  - B < 2^WIDTH-1: B <= B+1.
  - B == 2^WIDTH-1, WRAP=1: B <= 0, Overflow <= 1.
  - B == 2^WIDTH-1, WRAP=0: B holds, Overflow <= 1.
- En=1, Load=0, Dir=0:
  - B > 0: B <= B-1.
  - B == 0, WRAP=1: B <= 2^WIDTH-1, Underflow <= 1.
  - B == 0, WRAP=0: B holds, Underflow <= 1.
- En=0, Load=0: state holds. Dir is ignored.
- ClrFlags=1 clears both flags on the edge. If a new overflow/underflow event occurs on the same edge, that flag is set (set wins over clear).
- Flags stay set until ClrFlags or Reset.
- Latency: one cycle from input edge to Output/BinOut change.
- Successive Outputs differ in exactly one bit on every En step, including the wrap step. A saturating hold produces zero bit changes.
- All arithmetic is WIDTH-bit unsigned. The wrap boundary is detected by compare, not by carry-out.

Optional Feature:
- Macro GRAY_CNT_TC_EN.
- Defined: adds output port Tc (1 bit, registered, reset 0). Tc pulses high for exactly one cycle on the edge after the counter reaches the terminal value in the current direction: 2^WIDTH-1 when Dir=1, 0 when Dir=0, via an En step. A load to the terminal value does not pulse Tc.
- Undefined: no Tc port, no extra logic.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(WIDTH)
  - function gray2bin(WIDTH), used by benches for checking
  - constants DIR_UP=1, DIR_DOWN=0
- One natural sub-module: gray_enc, a combinational binary-to-Gray encoder of width WIDTH. It is instantiated for the next-state Output value and reused by the FIFO pointer blocks.

Test Plan:
- WIDTH=3, WRAP=1, reset, En=1, Dir=1 for 9 cycles -> Output 000,001,011,010,110,111,101,100,000. Overflow rises with the 100->000 step and stays 1.
- WIDTH=3, WRAP=1, from 0 with Dir=0, En=1 -> BinOut 7, Output 100, Underflow=1. Next step BinOut 6, Output 101.
- WIDTH=3, WRAP=0, count up to 7, 3 more En cycles -> BinOut stays 7, Output stays 100, Overflow=1. Then Dir=0 one step -> BinOut 6.
- Load=1, LoadVal=5 with En=1, Dir=1 simultaneously -> BinOut 5, Output 111, flags unchanged. Next En cycle -> BinOut 6, Output 101.
- Overflow set, then ClrFlags=1 on the same edge as a 7->0 wrap -> Overflow remains 1. ClrFlags alone next cycle -> Overflow 0.
- Mid-count (BinOut 4), Reset pulled low between clock edges -> Output/BinOut/flags 0 immediately, without waiting for an edge. After release, count resumes 0->1 on the first En edge.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family: code conversion, direction
// constants and the per-edge operation encoding.
package gray_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Conversion helpers work on a fixed wide word; callers zero-extend narrower codes.
  localparam int GRAY_FN_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
    logic [GRAY_FN_W-1:0] b;
    b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
    for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder; also reused by the FIFO pointer blocks.
module gray_enc #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

  assign gray[WIDTH-1] = bin[WIDTH-1];

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray counter with load, wrap/saturate and sticky flags.
// Define GRAY_CNT_TC_EN to add the registered terminal-count pulse output Tc.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int WRAP  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow
`ifdef GRAY_CNT_TC_EN
  ,
  output logic             Tc
`endif
);

  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_CNT = {WIDTH{1'b0}};

  logic [WIDTH-1:0] bin_reg,  bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             ovf_reg,  ovf_next;
  logic             unf_reg,  unf_next;
  logic             ovf_set,  unf_set;
  logic             at_max,   at_min;
  op_e              op;

  assign at_max = (bin_reg == MAX_CNT);
  assign at_min = (bin_reg == MIN_CNT);

  always_comb begin
    op = OP_HOLD;
    if (Load) begin
      op = OP_LOAD;
    end else if (En) begin
      op = (Dir == DIR_UP) ? OP_UP : OP_DOWN;
    end
  end

  // Boundaries are found by compare so saturate mode can hold without a carry path.
  always_comb begin
    bin_next = bin_reg;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    case (op)
      OP_LOAD: bin_next = LoadVal;
      OP_UP: begin
        if (at_max) begin
          ovf_set = 1'b1;
          if (WRAP != 0) bin_next = MIN_CNT;
        end else begin
          bin_next = bin_reg + 1'b1;
        end
      end
      OP_DOWN: begin
        if (at_min) begin
          unf_set = 1'b1;
          if (WRAP != 0) bin_next = MAX_CNT;
        end else begin
          bin_next = bin_reg - 1'b1;
        end
      end
      default: bin_next = bin_reg;
    endcase
  end

  // A new event on the same edge outranks the clear.
  assign ovf_next = ovf_set | (ovf_reg & ~ClrFlags);
  assign unf_next = unf_set | (unf_reg & ~ClrFlags);

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      ovf_reg  <= 1'b0;
      unf_reg  <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
      unf_reg  <= unf_next;
    end
  end

  assign BinOut    = bin_reg;
  assign Output    = gray_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;

`ifdef GRAY_CNT_TC_EN
  logic tc_reg, tc_next;

  // Only a count step that actually arrives at the end pulses; loads and saturating holds do not.
  always_comb begin
    tc_next = 1'b0;
    if (op == OP_UP && bin_next == MAX_CNT && !at_max) tc_next = 1'b1;
    if (op == OP_DOWN && bin_next == MIN_CNT && !at_min) tc_next = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= tc_next;
    end
  end

  assign Tc = tc_reg;
`endif

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: instance 0 wraps, instance 1 saturates (WIDTH=3).
module tb_gray_counter_n;
  import gray_pkg::*;

  typedef struct {
    int         d;
    logic [2:0] bin;
    logic [2:0] gray;
    logic       ovf;
    logic       unf;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en, dir, load, clr;
  logic [2:0] lv [2];
  logic [2:0] gray_o [2];
  logic [2:0] bin_o [2];
  logic [1:0] ovf, unf;
`ifdef GRAY_CNT_TC_EN
  logic [1:0] tc;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(3), .WRAP(1)) dut_wrap (
    .Clk(clk), .Reset(rst_n), .En(en[0]), .Dir(dir[0]), .Load(load[0]),
    .LoadVal(lv[0]), .ClrFlags(clr[0]), .Output(gray_o[0]), .BinOut(bin_o[0]),
    .Overflow(ovf[0]), .Underflow(unf[0])
`ifdef GRAY_CNT_TC_EN
    , .Tc(tc[0])
`endif
  );

  gray_counter_n #(.WIDTH(3), .WRAP(0)) dut_sat (
    .Clk(clk), .Reset(rst_n), .En(en[1]), .Dir(dir[1]), .Load(load[1]),
    .LoadVal(lv[1]), .ClrFlags(clr[1]), .Output(gray_o[1]), .BinOut(bin_o[1]),
    .Overflow(ovf[1]), .Underflow(unf[1])
`ifdef GRAY_CNT_TC_EN
    , .Tc(tc[1])
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus on instance d, with the hand-computed result after the edge.
  task automatic vec(input int d, input bit e, input bit dr, input bit ld,
                     input logic [2:0] lval, input bit cl,
                     input logic [2:0] eb, input logic [2:0] eg,
                     input bit eo, input bit eu, input string nm);
    exp_t x;
    @(negedge clk);
    en = '0; load = '0; clr = '0;
    en[d] = e; dir[d] = dr; load[d] = ld; lv[d] = lval; clr[d] = cl;
    x.d = d; x.bin = eb; x.gray = eg; x.ovf = eo; x.unf = eu; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    en = '0; load = '0; clr = '0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_bin%0d", nm, d), 32'(bin_o[d]), 32'd0);
      check($sformatf("%s_gray%0d", nm, d), 32'(gray_o[d]), 32'd0);
      check($sformatf("%s_flags%0d", nm, d), {30'd0, ovf[d], unf[d]}, 32'd0);
    end
  endtask

  // Monitor: every output update (just after each rising edge) retires one expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check({x.name, "_bin"},  32'(bin_o[x.d]),  32'(x.bin));
        check({x.name, "_gray"}, 32'(gray_o[x.d]), 32'(x.gray));
        check({x.name, "_ovf"},  32'(ovf[x.d]),    32'(x.ovf));
        check({x.name, "_unf"},  32'(unf[x.d]),    32'(x.unf));
        check({x.name, "_g2b"},  gray2bin(32'(gray_o[x.d])), 32'(x.bin));
        $display("txn %-14s dut%0d bin=%0d gray=%b ovf=%b unf=%b", x.name, x.d,
                 bin_o[x.d], gray_o[x.d], ovf[x.d], unf[x.d]);
      end
    end
  end

  initial begin
    en = '0; dir = '0; load = '0; clr = '0;
    lv[0] = '0; lv[1] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Wrapping counter: full up sweep, overflow on 7->0 and sticky afterwards
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd1, 3'b001, 0, 0, "up1");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd2, 3'b011, 0, 0, "up2");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd3, 3'b010, 0, 0, "up3");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd4, 3'b110, 0, 0, "up4");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd5, 3'b111, 0, 0, "up5");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd6, 3'b101, 0, 0, "up6");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd7, 3'b100, 0, 0, "up7");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd0, 3'b000, 1, 0, "wrap_up");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd1, 3'b001, 1, 0, "ovf_sticky");
    // Down through zero
    vec(0, 1, DIR_DOWN, 0, 3'd0, 0, 3'd0, 3'b000, 1, 0, "dn_to0");
    vec(0, 1, DIR_DOWN, 0, 3'd0, 0, 3'd7, 3'b100, 1, 1, "wrap_dn");
    vec(0, 1, DIR_DOWN, 0, 3'd0, 0, 3'd6, 3'b101, 1, 1, "dn6");
    // Clear racing a new overflow: overflow survives, underflow clears
    vec(0, 0, DIR_UP, 1, 3'd7, 0, 3'd7, 3'b100, 1, 1, "load7");
    vec(0, 1, DIR_UP, 0, 3'd0, 1, 3'd0, 3'b000, 1, 0, "clr_vs_wrap");
    vec(0, 0, DIR_UP, 0, 3'd0, 1, 3'd0, 3'b000, 0, 0, "clr_only");
    // Load beats En and sets no flags
    vec(0, 1, DIR_UP, 1, 3'd5, 0, 3'd5, 3'b111, 0, 0, "load_prio");
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd6, 3'b101, 0, 0, "after_load");
    vec(0, 0, DIR_DOWN, 0, 3'd0, 0, 3'd6, 3'b101, 0, 0, "hold");
    vec(0, 0, DIR_UP, 1, 3'd4, 0, 3'd4, 3'b110, 0, 0, "load4");

    // Saturating counter: underflow at 0, climb to 7, hold there
    vec(1, 1, DIR_DOWN, 0, 3'd0, 0, 3'd0, 3'b000, 0, 1, "sat_dn0");
    vec(1, 0, DIR_UP, 0, 3'd0, 1, 3'd0, 3'b000, 0, 0, "sat_clr");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd1, 3'b001, 0, 0, "s_up1");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd2, 3'b011, 0, 0, "s_up2");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd3, 3'b010, 0, 0, "s_up3");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd4, 3'b110, 0, 0, "s_up4");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd5, 3'b111, 0, 0, "s_up5");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd6, 3'b101, 0, 0, "s_up6");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd7, 3'b100, 0, 0, "s_up7");
    for (int i = 0; i < 3; i++) begin
      vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd7, 3'b100, 1, 0, $sformatf("sat_hold%0d", i));
    end
    vec(1, 1, DIR_DOWN, 0, 3'd0, 0, 3'd6, 3'b101, 1, 0, "sat_dn6");
    drain();

    // Asynchronous reset mid-cycle, held across an enabled edge
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    en[0] = 1'b1; dir[0] = DIR_UP;
    @(posedge clk);
    #1;
    check("rst_hold_bin0", 32'(bin_o[0]), 32'd0);
    check("rst_hold_ovf0", 32'(ovf[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = '0;
    vec(0, 1, DIR_UP, 0, 3'd0, 0, 3'd1, 3'b001, 0, 0, "post_rst0");
    vec(1, 1, DIR_UP, 0, 3'd0, 0, 3'd1, 3'b001, 0, 0, "post_rst1");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
